pipe_field: RTL and testbench

- Consumer end of the pipe-pattern interface.
- Accepts one-cycle pipe column patterns from the pattern generator and holds them in a COLS x ROWS playfield. Shifts the playfield one column left per scroll tick.
- Checks the bird position against the column it occupies and keeps the score.
- Its read port feeds the LED-matrix driver; its game_over output drives the generator's gameOver input.

---
 rtl/pipe_field.sv | 114 +++++++++++
 tb/tb_pipe_field.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_field.sv
// Pipe playfield: holds COLS x ROWS pipe columns, scrolls left on scroll_tick, detects bird collision, keeps score.
// Latency: entry column visible one cycle after the capturing tick; collide/game_over one cycle after the hit condition.
// Backpressure: none; single-cycle inputs are consumed immediately. Optional 2-column hitbox via PIPE_FIELD_WIDE_HITBOX_EN.
module pipe_field #(
  parameter int ROWS     = 15,
  parameter int COLS     = 16,
  parameter int BIRD_COL = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     scroll_tick,
  input  logic [ROWS-1:0]          pattern_in,
  input  logic [3:0]               bird_row,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic [ROWS-1:0]          rd_data,
  output logic                     game_over,
  output logic                     collide,
  output logic [6:0]               score
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [ROWS-1:0] ROW_ONE   = {{(ROWS-1){1'b0}}, 1'b1};
  localparam logic [6:0]      SCORE_MAX = 7'd99;

  state_t          state_q;
  state_t          state_d;
  logic [ROWS-1:0] col [COLS];
  logic [ROWS-1:0] pend;
  logic            pend_v;
  logic [ROWS-1:0] entry;
  logic [ROWS-1:0] row_mask;
  logic            hit;

  // Collision test on the registered field; rows past the top count as a ground/ceiling hit.
  always_comb begin
    row_mask = ROW_ONE << bird_row;
    hit      = |(col[BIRD_COL] & row_mask);
`ifdef PIPE_FIELD_WIDE_HITBOX_EN
    hit      = hit | (|(col[BIRD_COL+1] & row_mask));
`endif
    if (int'(bird_row) >= ROWS) hit = 1'b1;
  end

  // Entry column source: same-cycle pattern bypasses the pending slot, which beats an empty column.
  always_comb begin
    entry = pend_v ? pend : '0;
    if (|pattern_in) entry = pattern_in;
  end

  // Game state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: start launches or restarts, a hit ends the run; start during a run is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (hit)   state_d = OVER;
      OVER:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Field, pending slot, score and collide pulse; a hit freezes everything for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) col[i] <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      score   <= '0;
      collide <= 1'b0;
    end else begin
      collide <= 1'b0;
      case (state_q)
        RUN: begin
          if (hit) begin
            collide <= 1'b1;
          end else if (scroll_tick) begin
            for (int i = 0; i < COLS-1; i++) col[i] <= col[i+1];
            col[COLS-1] <= entry;
            pend_v      <= 1'b0;
            if ((|col[BIRD_COL]) && (score < SCORE_MAX)) score <= score + 7'd1;
          end else if (|pattern_in) begin
            pend   <= pattern_in;
            pend_v <= 1'b1;
          end
        end
        OVER: begin
          if (start) begin
            for (int i = 0; i < COLS; i++) col[i] <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            score  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational read port for the LED driver; out-of-range columns read blank.
  always_comb begin
    rd_data = '0;
    if (int'(rd_col) < COLS) rd_data = col[rd_col];
  end

  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_pipe_field.sv
module tb_pipe_field;
  localparam int ROWS     = 15;
  localparam int COLS     = 16;
  localparam int BIRD_COL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        scroll_tick;
  logic [14:0] pattern_in;
  logic [3:0]  bird_row;
  logic [3:0]  rd_col;
  logic [14:0] rd_data;
  logic        game_over;
  logic        collide;
  logic [6:0]  score;

  pipe_field #(.ROWS(ROWS), .COLS(COLS), .BIRD_COL(BIRD_COL)) dut (
    .clk(clk), .reset(reset), .start(start), .scroll_tick(scroll_tick),
    .pattern_in(pattern_in), .bird_row(bird_row), .rd_col(rd_col),
    .rd_data(rd_data), .game_over(game_over), .collide(collide), .score(score)
  );

  always #50 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the field is a queue of columns, front = exit column 0.
  logic [14:0] m_q[$];
  logic [14:0] m_pend;
  bit          m_pend_v;
  int          m_score;
  int          m_mode;      // 0 idle, 1 running, 2 game over
  bit          m_collide;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int c = 0; c < COLS; c++) m_q.push_back(15'h0);
    m_pend   = 15'h0;
    m_pend_v = 1'b0;
    m_score  = 0;
  endtask

  function automatic bit model_hit(input logic [3:0] row);
    logic [14:0] v;
    bit h;
    if (int'(row) >= ROWS) return 1'b1;
    v = m_q[BIRD_COL];
    h = v[row];
`ifdef PIPE_FIELD_WIDE_HITBOX_EN
    v = m_q[BIRD_COL+1];
    h = h | v[row];
`endif
    return h;
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit tk,
                            input logic [14:0] pat, input logic [3:0] row);
    logic [14:0] e;
    m_collide = 1'b0;
    if (rst) begin
      model_clear();
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      if (model_hit(row)) begin
        m_mode    = 2;
        m_collide = 1'b1;
      end else if (tk) begin
        if (m_q[BIRD_COL] != 15'h0) m_score = (m_score >= 99) ? 99 : m_score + 1;
        e = (pat != 15'h0) ? pat : (m_pend_v ? m_pend : 15'h0);
        void'(m_q.pop_front());
        m_q.push_back(e);
        m_pend_v = 1'b0;
      end else if (pat != 15'h0) begin
        m_pend   = pat;
        m_pend_v = 1'b1;
      end
    end else begin
      if (st) begin
        model_clear();
        m_mode = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance model, check outputs #1 after the edge.
  task automatic step(input bit st, input bit tk, input logic [14:0] pat,
                      input logic [3:0] row, input string tag);
    logic [3:0] rc;
    rc          = 4'($urandom_range(0, COLS-1));
    start       = st;
    scroll_tick = tk;
    pattern_in  = pat;
    bird_row    = row;
    rd_col      = rc;
    model_step(reset, st, tk, pat, row);
    @(posedge clk);
    #1;
    chk({tag, "/game_over"}, 32'(game_over), 32'(m_mode == 2));
    chk({tag, "/collide"},   32'(collide),   32'(m_collide));
    chk({tag, "/score"},     32'(score),     32'(m_score));
    chk({tag, "/rd_data"},   32'(rd_data),   32'(m_q[rc]));
  endtask

  task automatic sweep(input string tag);
    for (int c = 0; c < COLS; c++) begin
      rd_col = 4'(c);
      #1;
      chk($sformatf("%s/col%0d", tag, c), 32'(rd_data), 32'(m_q[c]));
    end
  endtask

  task automatic read_col(input int c);
    rd_col = 4'(c);
    #1;
  endtask

  localparam logic [14:0] P1 = 15'b110000011111111;
  localparam logic [14:0] P2 = 15'b111111111000001;

  initial begin
    reset = 1'b1; start = 1'b0; scroll_tick = 1'b0;
    pattern_in = 15'h0; bird_row = 4'd0; rd_col = 4'd0;
    model_clear();
    m_mode = 0;
    m_collide = 1'b0;

    // Reset state.
    step(0, 0, 15'h0, 4'd0, "rst0");
    step(0, 0, 15'h0, 4'd0, "rst1");
    reset = 1'b0;
    sweep("rst_field");

    // Idle ignores ticks and patterns.
    step(0, 1, 15'h7FFF, 4'd0, "idle_tick");
    sweep("idle_field");

    // Entry latency and travel to the bird column, then one scored pass.
    step(1, 0, 15'h0, 4'd10, "start");
    step(0, 1, P1, 4'd10, "tp1_tick");
    read_col(15);
    chk("tp1_entry", 32'(rd_data), 32'h60FF);
    for (int i = 0; i < 12; i++) step(0, 1, 15'h0, 4'd10, "tp1_travel");
    read_col(3);
    chk("tp1_at_bird", 32'(rd_data), 32'h60FF);
    step(0, 1, 15'h0, 4'd10, "tp1_pass");
    chk("tp1_score", 32'(score), 32'd1);
    chk("tp1_no_collide", 32'(collide), 32'd0);

    // Collision, freeze in OVER, restart.
    step(0, 1, P2, 4'd2, "tp2_tick");
    for (int i = 0; i < 12; i++) step(0, 1, 15'h0, 4'd2, "tp2_travel");
    step(0, 0, 15'h0, 4'd0, "tp2_hit");
    chk("tp2_collide", 32'(collide), 32'd1);
    chk("tp2_game_over", 32'(game_over), 32'd1);
    step(0, 0, 15'h0, 4'd0, "tp2_after");
    chk("tp2_collide_pulse", 32'(collide), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 15'h5555, 4'd0, "tp2_frozen");
    sweep("tp2_frozen_field");
    step(1, 0, 15'h0, 4'd5, "tp2_restart");
    chk("tp2_restart_score", 32'(score), 32'd0);
    chk("tp2_restart_go", 32'(game_over), 32'd0);
    sweep("tp2_cleared");

    // Out-of-range bird row.
    step(0, 0, 15'h0, 4'd15, "tp3_ground");
    chk("tp3_game_over", 32'(game_over), 32'd1);
    step(1, 0, 15'h0, 4'd5, "tp3_restart");

    // Pending slot: latest wins; same-cycle bypass beats pending.
    step(0, 0, 15'h0003, 4'd5, "tp4_A");
    step(0, 0, 15'h0700, 4'd5, "tp4_B");
    step(0, 1, 15'h0, 4'd5, "tp4_tick");
    read_col(15);
    chk("tp4_entry_B", 32'(rd_data), 32'h0700);
    step(0, 0, 15'h1111, 4'd5, "tp4_D");
    step(0, 1, 15'h2222, 4'd5, "tp4_C");
    read_col(15);
    chk("tp4_entry_C", 32'(rd_data), 32'h2222);
    step(0, 1, 15'h0, 4'd5, "tp4_empty");
    read_col(15);
    chk("tp4_entry_0", 32'(rd_data), 32'h0);

    // Score saturation.
    for (int i = 0; i < 120; i++) step(0, 1, 15'h7F7F, 4'd7, "tp5_run");
    chk("tp5_sat", 32'(score), 32'd99);
    reset = 1'b1;
    step(0, 1, 15'h7F7F, 4'd7, "tp5_reset");
    reset = 1'b0;
    chk("tp5_reset_score", 32'(score), 32'd0);
    sweep("tp5_reset_field");
    for (int i = 0; i < 3; i++) step(0, 1, 15'h7F7F, 4'd7, "tp5_idle");
    sweep("tp5_idle_field");
    step(1, 0, 15'h0, 4'd5, "tp5_start");

    // Blocking bit only in the column ahead of the bird.
    step(0, 1, 15'h0001, 4'd5, "tp6_tick");
    for (int i = 0; i < 11; i++) step(0, 1, 15'h0, 4'd5, "tp6_travel");
    step(0, 0, 15'h0, 4'd0, "tp6_probe");
`ifdef PIPE_FIELD_WIDE_HITBOX_EN
    chk("tp6_wide_collide", 32'(collide), 32'd1);
`else
    chk("tp6_narrow_collide", 32'(collide), 32'd0);
`endif
    step(1, 0, 15'h0, 4'd5, "tp6_restart");

    // Randomized play against the model.
    for (int i = 0; i < 1500; i++) begin
      bit st, tk;
      logic [14:0] pat;
      logic [3:0]  row;
      st  = ($urandom % 40) == 0;
      tk  = ($urandom % 3) == 0;
      pat = (($urandom % 4) == 0) ? 15'($urandom) : 15'h0;
      row = 4'($urandom % 16);
      reset = (($urandom % 500) == 0);
      step(st, tk, pat, row, "rnd");
      reset = 1'b0;
      if ((i % 100) == 99) sweep("rnd_field");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
